// File: rtl/pwm_deadtime_gen_pkg.sv
// Shared definitions for the PWM dead-time generator.
// Holds the channel FSM encoding and the dead-time counter reset value.
package pwm_deadtime_gen_pkg;

  typedef enum logic [2:0] {
    StOff  = 3'd0,
    StLsOn = 3'd1,
    StDtR  = 3'd2,
    StHsOn = 3'd3,
    StDtF  = 3'd4
  } dt_state_e;

  localparam int unsigned DtCntRst = 0;

endpackage

// File: rtl/pwm_deadtime_gen_channel.sv
// One complementary channel: dead-time FSM, down-counter and raw (pre-polarity) drive registers.
// Drives follow the FSM state one cycle later, so an edge on the registered PWM reaches the pins two edges on.
module pwm_deadtime_gen_channel
  import pwm_deadtime_gen_pkg::*;
#(
  parameter int unsigned DT_BITS = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               run_i,
  input  logic               pwm_i,
  input  logic [DT_BITS-1:0] dt_rise_i,
  input  logic [DT_BITS-1:0] dt_fall_i,
  output logic               hs_o,
  output logic               ls_o,
  output logic               dt_active_o
);

  localparam logic [DT_BITS-1:0] CntOne = DT_BITS'(1);

  dt_state_e          r_state;
  logic [DT_BITS-1:0] r_cnt;
  logic               r_hs;
  logic               r_ls;
  logic               r_dt_active;
  logic               w_cnt_last;

  // Zero is only seen when OFF exits with a zero dead time; treat it as the final count.
  assign w_cnt_last = (r_cnt <= CntOne);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StOff;
      r_cnt       <= DT_BITS'(DtCntRst);
      r_hs        <= 1'b0;
      r_ls        <= 1'b0;
      r_dt_active <= 1'b0;
    end else begin
      r_hs        <= run_i & (r_state == StHsOn);
      r_ls        <= run_i & (r_state == StLsOn);
      r_dt_active <= run_i & (r_state inside {StOff, StDtR, StDtF});
      if (!run_i) begin
        r_state <= StOff;
      end else begin
        case (r_state)
          StOff: begin
            if (pwm_i) begin
              r_state <= StDtR;
              r_cnt   <= dt_rise_i;
            end else begin
              r_state <= StDtF;
              r_cnt   <= dt_fall_i;
            end
          end
          StLsOn: begin
            if (pwm_i) begin
              r_cnt   <= dt_rise_i;
              r_state <= (dt_rise_i == '0) ? StHsOn : StDtR;
            end
          end
          StDtR: begin
            if (!pwm_i) r_state <= StLsOn;
            else if (w_cnt_last) r_state <= StHsOn;
            else r_cnt <= r_cnt - CntOne;
          end
          StHsOn: begin
            if (!pwm_i) begin
              r_cnt   <= dt_fall_i;
              r_state <= (dt_fall_i == '0) ? StLsOn : StDtF;
            end
          end
          StDtF: begin
            if (pwm_i) r_state <= StHsOn;
            else if (w_cnt_last) r_state <= StLsOn;
            else r_cnt <= r_cnt - CntOne;
          end
          default: r_state <= StOff;
        endcase
      end
    end
  end

  assign hs_o        = r_hs;
  assign ls_o        = r_ls;
  assign dt_active_o = r_dt_active;

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM pairs with programmable dead time on both edges, one channel per pwm_i bit.
// Define PWM_DT_FAULT_EN to add the sticky fault shutdown (fault_i, fault_clr_i, fault_o).
module pwm_deadtime_gen
  import pwm_deadtime_gen_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned DT_BITS = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
`ifdef PWM_DT_FAULT_EN
  input  logic               fault_i,
  input  logic               fault_clr_i,
  output logic               fault_o,
`endif
  input  logic               cfg_en_i,
  input  logic               cfg_update_i,
  input  logic [DT_BITS-1:0] cfg_dt_rise_i,
  input  logic [DT_BITS-1:0] cfg_dt_fall_i,
  input  logic [N_CH-1:0]    cfg_pol_hs_i,
  input  logic [N_CH-1:0]    cfg_pol_ls_i,
  input  logic [N_CH-1:0]    pwm_i,
  output logic [N_CH-1:0]    hs_o,
  output logic [N_CH-1:0]    ls_o,
  output logic [N_CH-1:0]    dt_active_o
);

  logic [N_CH-1:0]    r_pwm;
  logic [DT_BITS-1:0] r_dt_rise;
  logic [DT_BITS-1:0] r_dt_fall;
  logic [N_CH-1:0]    w_hs;
  logic [N_CH-1:0]    w_ls;
  logic               w_run;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pwm     <= '0;
      r_dt_rise <= DT_BITS'(DtCntRst);
      r_dt_fall <= DT_BITS'(DtCntRst);
    end else begin
      r_pwm <= pwm_i;
      if (cfg_update_i) begin
        r_dt_rise <= cfg_dt_rise_i;
        r_dt_fall <= cfg_dt_fall_i;
      end
    end
  end

`ifdef PWM_DT_FAULT_EN
  logic r_fault;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_fault <= 1'b0;
    else if (fault_i) r_fault <= 1'b1;
    else if (fault_clr_i) r_fault <= 1'b0;
  end

  // A raw fault_i blocks the same edge so the pins drop without waiting for the latch.
  assign w_run   = cfg_en_i & ~fault_i & ~r_fault;
  assign fault_o = r_fault;
`else
  assign w_run = cfg_en_i;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pwm_deadtime_gen_channel #(
      .DT_BITS (DT_BITS)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .run_i       (w_run),
      .pwm_i       (r_pwm[g]),
      .dt_rise_i   (r_dt_rise),
      .dt_fall_i   (r_dt_fall),
      .hs_o        (w_hs[g]),
      .ls_o        (w_ls[g]),
      .dt_active_o (dt_active_o[g])
    );
  end

  assign hs_o = w_hs ^ cfg_pol_hs_i;
  assign ls_o = w_ls ^ cfg_pol_ls_i;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Self-checking bench for pwm_deadtime_gen: directed edge-timing scenarios plus randomized traffic
// against a committed-side / dead-gap reference model. Fault scenario built when PWM_DT_FAULT_EN is set.
module tb_pwm_deadtime_gen;

  localparam int N_CH    = 4;
  localparam int DT_BITS = 8;

  logic               clk  = 1'b0;
  logic               rst  = 1'b1;
  logic               en   = 1'b0;
  logic               upd  = 1'b0;
  logic [DT_BITS-1:0] dtr  = '0;
  logic [DT_BITS-1:0] dtf  = '0;
  logic [N_CH-1:0]    polh = '0;
  logic [N_CH-1:0]    poll = '0;
  logic [N_CH-1:0]    pwm  = '0;
  logic [N_CH-1:0]    hs;
  logic [N_CH-1:0]    ls;
  logic [N_CH-1:0]    dta;
`ifdef PWM_DT_FAULT_EN
  logic               flt  = 1'b0;
  logic               fclr = 1'b0;
  logic               fo;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each channel has a committed side (-1 none, 0 low, 1 high) and an optional
  // dead gap still to wait before committing to m_goal. Off = no side and no gap.
  int              m_side [N_CH];
  int              m_gap  [N_CH];
  int              m_goal [N_CH];
  logic [N_CH-1:0] m_pq;
  int              m_rise;
  int              m_fall;
  logic            m_fault;
  logic [N_CH-1:0] e_hs;
  logic [N_CH-1:0] e_ls;
  logic [N_CH-1:0] e_dta;

  always #5 clk = ~clk;

  pwm_deadtime_gen #(
    .N_CH    (N_CH),
    .DT_BITS (DT_BITS)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
`ifdef PWM_DT_FAULT_EN
    .fault_i       (flt),
    .fault_clr_i   (fclr),
    .fault_o       (fo),
`endif
    .cfg_en_i      (en),
    .cfg_update_i  (upd),
    .cfg_dt_rise_i (dtr),
    .cfg_dt_fall_i (dtf),
    .cfg_pol_hs_i  (polh),
    .cfg_pol_ls_i  (poll),
    .pwm_i         (pwm),
    .hs_o          (hs),
    .ls_o          (ls),
    .dt_active_o   (dta)
  );

  task automatic model_step();
    logic run;
    int   p;
    int   dp;
    logic idle;
    logic waiting;
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        m_side[c] = -1;
        m_gap[c]  = 0;
        m_goal[c] = 0;
      end
      m_pq = '0; m_rise = 0; m_fall = 0; m_fault = 1'b0;
      e_hs = '0; e_ls = '0; e_dta = '0;
      return;
    end
    run = en;
`ifdef PWM_DT_FAULT_EN
    run = en && !flt && !m_fault;
`endif
    for (int c = 0; c < N_CH; c++) begin
      p       = m_pq[c] ? 1 : 0;
      dp      = (p == 1) ? m_rise : m_fall;
      idle    = (m_side[c] == -1) && (m_gap[c] == 0);
      waiting = (m_gap[c] > 0);
      e_hs[c]  = run && !waiting && (m_side[c] == 1);
      e_ls[c]  = run && !waiting && (m_side[c] == 0);
      e_dta[c] = run && (idle || waiting);
      if (!run) begin
        m_side[c] = -1;
        m_gap[c]  = 0;
      end else if (idle) begin
        m_gap[c]  = (dp == 0) ? 1 : dp;
        m_goal[c] = p;
      end else if (waiting) begin
        if (p != m_goal[c]) begin
          m_side[c] = p;
          m_gap[c]  = 0;
        end else if (m_gap[c] <= 1) begin
          m_side[c] = m_goal[c];
          m_gap[c]  = 0;
        end else begin
          m_gap[c] = m_gap[c] - 1;
        end
      end else if (p != m_side[c]) begin
        if (dp == 0) m_side[c] = p;
        else begin
          m_gap[c]  = dp;
          m_goal[c] = p;
        end
      end
    end
    m_pq = pwm;
    if (upd) begin
      m_rise = int'(dtr);
      m_fall = int'(dtf);
    end
`ifdef PWM_DT_FAULT_EN
    if (flt) m_fault = 1'b1;
    else if (fclr) m_fault = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Load dead times, then enable with pwm low so every channel ends up low-side on.
  task automatic settle_low(input int dr, input int df);
    rst = 1'b0; en = 1'b0; pwm = '0; polh = '0; poll = '0;
    dtr = DT_BITS'(dr); dtf = DT_BITS'(df); upd = 1'b1;
    tick();
    upd = 1'b0; en = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; polh = 4'b0101; poll = 4'b0011; pwm = '1;
    tick(); tick();
    if (hs !== 4'b0101) begin n_errors++; $display("FAIL reset_hs got=%b want=0101", hs); end
    n_checks++;
    if (ls !== 4'b0011) begin n_errors++; $display("FAIL reset_ls got=%b want=0011", ls); end
    n_checks++;
    if (dta !== 4'b0000) begin n_errors++; $display("FAIL reset_dta got=%b want=0000", dta); end
    n_checks++;
    rst = 1'b0; en = 1'b0; pwm = '0;
  endtask

  task automatic test_edge_timing();
    settle_low(3, 2);
    if (ls !== 4'b1111) begin n_errors++; $display("FAIL settle_ls got=%b want=1111", ls); end
    n_checks++;
    pwm[0] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (ls[0] !== (j < 2)) begin
        n_errors++; $display("FAIL rise_ls j=%0d got=%b want=%b", j, ls[0], (j < 2));
      end
      n_checks++;
      if (hs[0] !== (j >= 5)) begin
        n_errors++; $display("FAIL rise_hs j=%0d got=%b want=%b", j, hs[0], (j >= 5));
      end
      n_checks++;
      if (dta[0] !== (j >= 2 && j < 5)) begin
        n_errors++; $display("FAIL rise_dta j=%0d got=%b want=%b", j, dta[0], (j >= 2 && j < 5));
      end
      n_checks++;
    end
    pwm[0] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (hs[0] !== (j < 2)) begin
        n_errors++; $display("FAIL fall_hs j=%0d got=%b want=%b", j, hs[0], (j < 2));
      end
      n_checks++;
      if (ls[0] !== (j >= 4)) begin
        n_errors++; $display("FAIL fall_ls j=%0d got=%b want=%b", j, ls[0], (j >= 4));
      end
      n_checks++;
      if (dta[0] !== (j >= 2 && j < 4)) begin
        n_errors++; $display("FAIL fall_dta j=%0d got=%b want=%b", j, dta[0], (j >= 2 && j < 4));
      end
      n_checks++;
    end
    if (ls[3:1] !== 3'b111) begin n_errors++; $display("FAIL idle_ch_ls got=%b want=111", ls[3:1]); end
    n_checks++;
  endtask

  task automatic test_glitch();
    settle_low(5, 5);
    pwm[1] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (hs[1] !== 1'b0) begin n_errors++; $display("FAIL glitch_hs j=%0d got=%b want=0", j, hs[1]); end
      n_checks++;
      if (ls[1] !== !(j == 2 || j == 3)) begin
        n_errors++; $display("FAIL glitch_ls j=%0d got=%b want=%b", j, ls[1], !(j == 2 || j == 3));
      end
      n_checks++;
      if (j == 1) pwm[1] = 1'b0;
    end
  endtask

  task automatic test_zero_dt();
    logic [N_CH-1:0] hist [40];
    settle_low(0, 0);
    for (int j = 0; j < 40; j++) begin
      pwm     = j[0] ? 4'b1010 : 4'b0101;
      hist[j] = pwm;
      tick();
      if ((hs & ls) !== '0) begin n_errors++; $display("FAIL zero_overlap j=%0d hs=%b ls=%b", j, hs, ls); end
      n_checks++;
      if (j >= 3) begin
        if (hs !== hist[j-2]) begin
          n_errors++; $display("FAIL zero_hs j=%0d got=%b want=%b", j, hs, hist[j-2]);
        end
        n_checks++;
        if (ls !== ~hist[j-2]) begin
          n_errors++; $display("FAIL zero_ls j=%0d got=%b want=%b", j, ls, ~hist[j-2]);
        end
        n_checks++;
      end
    end
  endtask

  task automatic test_enable();
    settle_low(4, 4);
    pwm = 4'b0001;
    repeat (3) tick();
    en = 1'b0;
    tick();
    if (hs !== 4'b0000) begin n_errors++; $display("FAIL dis_hs got=%b want=0000", hs); end
    n_checks++;
    if (ls !== 4'b0000) begin n_errors++; $display("FAIL dis_ls got=%b want=0000", ls); end
    n_checks++;
    if (dta !== 4'b0000) begin n_errors++; $display("FAIL dis_dta got=%b want=0000", dta); end
    n_checks++;
    repeat (2) tick();
    en = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (hs !== ((j >= 5) ? 4'b0001 : 4'b0000)) begin
        n_errors++; $display("FAIL reen_hs j=%0d got=%b", j, hs);
      end
      n_checks++;
      if (ls !== ((j >= 5) ? 4'b1110 : 4'b0000)) begin
        n_errors++; $display("FAIL reen_ls j=%0d got=%b", j, ls);
      end
      n_checks++;
      if (dta !== ((j < 5) ? 4'b1111 : 4'b0000)) begin
        n_errors++; $display("FAIL reen_dta j=%0d got=%b", j, dta);
      end
      n_checks++;
    end
  endtask

`ifdef PWM_DT_FAULT_EN
  task automatic test_fault();
    settle_low(3, 3);
    pwm = 4'b0001;
    repeat (8) tick();
    if (hs !== 4'b0001) begin n_errors++; $display("FAIL fault_pre_hs got=%b want=0001", hs); end
    n_checks++;
    flt = 1'b1;
    tick();
    flt = 1'b0;
    if ((hs | ls) !== 4'b0000) begin n_errors++; $display("FAIL fault_off hs=%b ls=%b", hs, ls); end
    n_checks++;
    if (fo !== 1'b1) begin n_errors++; $display("FAIL fault_set got=%b want=1", fo); end
    n_checks++;
    repeat (3) tick();
    if ((hs | ls | dta) !== 4'b0000 || fo !== 1'b1) begin
      n_errors++; $display("FAIL fault_hold hs=%b ls=%b dta=%b fo=%b", hs, ls, dta, fo);
    end
    n_checks++;
    flt = 1'b1; fclr = 1'b1;
    tick();
    flt = 1'b0; fclr = 1'b0;
    if (fo !== 1'b1) begin n_errors++; $display("FAIL fault_prio got=%b want=1", fo); end
    n_checks++;
    fclr = 1'b1;
    tick();
    fclr = 1'b0;
    if (fo !== 1'b0) begin n_errors++; $display("FAIL fault_clr got=%b want=0", fo); end
    n_checks++;
    for (int j = 0; j < 7; j++) begin
      tick();
      if (hs[0] !== (j >= 4)) begin
        n_errors++; $display("FAIL fault_rehs j=%0d got=%b want=%b", j, hs[0], (j >= 4));
      end
      n_checks++;
      if (dta[0] !== (j < 4)) begin
        n_errors++; $display("FAIL fault_redta j=%0d got=%b want=%b", j, dta[0], (j < 4));
      end
      n_checks++;
    end
  endtask
`endif

  task automatic test_random();
    rst = 1'b0; en = 1'b1; polh = 4'b0110; poll = 4'b0011;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 5) == 0) pwm[c] = ~pwm[c];
      end
      upd = ($urandom_range(0, 19) == 0);
      dtr = DT_BITS'($urandom_range(0, 6));
      dtf = DT_BITS'($urandom_range(0, 6));
      if ($urandom_range(0, 99) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 199) == 0) begin
        polh = N_CH'($urandom);
        poll = N_CH'($urandom);
      end
      tick();
      if (hs !== (e_hs ^ polh)) begin
        n_errors++; $display("FAIL rand_hs i=%0d got=%b want=%b", i, hs, e_hs ^ polh);
      end
      n_checks++;
      if (ls !== (e_ls ^ poll)) begin
        n_errors++; $display("FAIL rand_ls i=%0d got=%b want=%b", i, ls, e_ls ^ poll);
      end
      n_checks++;
      if (dta !== e_dta) begin
        n_errors++; $display("FAIL rand_dta i=%0d got=%b want=%b", i, dta, e_dta);
      end
      n_checks++;
      if (((hs ^ polh) & (ls ^ poll)) !== '0) begin
        n_errors++; $display("FAIL rand_overlap i=%0d hs=%b ls=%b", i, hs, ls);
      end
      n_checks++;
    end
    rst = 1'b0; upd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_timing();
    test_glitch();
    test_zero_dt();
    test_enable();
`ifdef PWM_DT_FAULT_EN
    test_fault();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
